// File: rtl/output_drain_encoder.sv
// Output drain encoder: reads accumulator results from the output buffer, post-processes each value
// (optional ReLU, round-half-up shift, 8-bit saturation) and re-encodes groups of BUS_W values as
// a zero-value-compressed beat: a sparsemap plus packed nonzero bytes.
// Optional feature macro: DRAIN_RELU_EN (ReLU + unsigned [0,255] output; default is signed).
module output_drain_encoder #(
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned BUF_NUM = 16,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         drain_start_i,
  input  logic [$clog2(BUF_NUM)-1:0]   drain_first_i,
  input  logic [$clog2(BUF_NUM):0]     drain_cnt_i,
  input  logic [4:0]                   scale_shift_i,
  output logic [$clog2(BUF_NUM)-1:0]   out_buf_sel_o,
  input  logic signed [OUT_W-1:0]      out_buf_dat_i,
  output logic                         enc_valid_o,
  input  logic                         enc_ready_i,
  output logic [BUS_W-1:0]             enc_sparsemap_o,
  output logic [BUS_W*8-1:0]           enc_nonzero_data_o,
  output logic [CNT_W-1:0]             enc_wr_count_o,
  output logic                         enc_last_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned IdxW  = $clog2(BUF_NUM);
  localparam int unsigned LaneW = $clog2(BUS_W);

`ifdef DRAIN_RELU_EN
  localparam logic signed [OUT_W:0] SatHi = 255;
`else
  localparam logic signed [OUT_W:0] SatHi = 127;
  localparam logic signed [OUT_W:0] SatLo = -128;
`endif

  typedef enum logic [2:0] {StIdle, StRead, StCapt, StEmit, StDone} state_e;

  state_e               r_state;
  logic [IdxW-1:0]      r_first;
  logic [IdxW:0]        r_cnt;
  logic [4:0]           r_shift;
  logic [IdxW:0]        r_idx;
  logic [IdxW-1:0]      r_sel;
  logic [BUS_W-1:0]     r_map;
  logic [BUS_W*8-1:0]   r_data;
  logic [LaneW-1:0]     r_nz_ptr;
  logic [CNT_W-1:0]     r_wr_count;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;

  logic signed [OUT_W-1:0] w_relu;
  logic signed [OUT_W:0]   w_half;
  logic signed [OUT_W:0]   w_sum;
  logic signed [OUT_W:0]   w_rnd;
  logic [7:0]              w_q;
  logic [IdxW:0]           w_idx_inc;
  logic                    w_group_end;
  logic [IdxW-1:0]         w_sel_capt;
  logic [IdxW-1:0]         w_sel_emit;

  // Requantise the captured accumulator value and derive the next read selects.
  always_comb begin
`ifdef DRAIN_RELU_EN
    w_relu = out_buf_dat_i[OUT_W-1] ? '0 : out_buf_dat_i;
`else
    w_relu = out_buf_dat_i;
`endif
    w_half = '0;
    if (r_shift != 5'd0) begin
      w_half = {{OUT_W{1'b0}}, 1'b1} << (r_shift - 5'd1);
    end
    // One extra bit so the rounding increment cannot overflow.
    w_sum = {w_relu[OUT_W-1], w_relu} + w_half;
    w_rnd = w_sum >>> r_shift;
`ifdef DRAIN_RELU_EN
    if (w_rnd > SatHi) w_q = 8'hFF;
    else               w_q = w_rnd[7:0];
`else
    if (w_rnd > SatHi)      w_q = 8'h7F;
    else if (w_rnd < SatLo) w_q = 8'h80;
    else                    w_q = w_rnd[7:0];
`endif
    w_idx_inc   = r_idx + (IdxW+1)'(1);
    w_group_end = (w_idx_inc[LaneW-1:0] == '0) || (w_idx_inc == r_cnt);
    w_sel_capt  = r_first + w_idx_inc[IdxW-1:0];
    w_sel_emit  = r_first + r_idx[IdxW-1:0];
  end

  // Drain sequencer: read, capture/encode, emit beat, repeat; all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_first    <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_sel      <= '0;
      r_map      <= '0;
      r_data     <= '0;
      r_nz_ptr   <= '0;
      r_wr_count <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (drain_start_i) begin
            r_first    <= drain_first_i;
            r_cnt      <= drain_cnt_i;
            r_shift    <= scale_shift_i;
            r_idx      <= '0;
            r_map      <= '0;
            r_data     <= '0;
            r_nz_ptr   <= '0;
            r_wr_count <= '0;
            r_busy     <= 1'b1;
            if (drain_cnt_i == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRead;
              r_sel   <= drain_first_i;
            end
          end
        end
        StRead: r_state <= StCapt;
        StCapt: begin
          r_idx <= w_idx_inc;
          if (w_q != 8'h00) begin
            r_map[r_idx[LaneW-1:0]]  <= 1'b1;
            r_data[8*r_nz_ptr +: 8]  <= w_q;
            r_nz_ptr                 <= r_nz_ptr + LaneW'(1);
          end
          if (w_group_end) begin
            r_state <= StEmit;
            r_valid <= 1'b1;
            r_last  <= (w_idx_inc == r_cnt);
          end else begin
            r_state <= StRead;
            r_sel   <= w_sel_capt;
          end
        end
        StEmit: begin
          if (enc_ready_i) begin
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_wr_count <= r_wr_count + CNT_W'(1);
            r_map      <= '0;
            r_data     <= '0;
            r_nz_ptr   <= '0;
            if (r_last) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRead;
              r_sel   <= w_sel_emit;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_buf_sel_o      = r_sel;
  assign enc_valid_o        = r_valid;
  assign enc_sparsemap_o    = r_map;
  assign enc_nonzero_data_o = r_data;
  assign enc_wr_count_o     = r_wr_count;
  assign enc_last_o         = r_last;
  assign busy_o             = r_busy;
  assign done_o             = r_done;

endmodule

// File: tb/tb_output_drain_encoder.sv
// Bench for output_drain_encoder: behavioural output-buffer memory, directed and randomized drains
// checked against a per-value arithmetic model grouped into expected beats.
module tb_output_drain_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        drain_start_i;
  logic [3:0]  drain_first_i;
  logic [4:0]  drain_cnt_i;
  logic [4:0]  scale_shift_i;
  logic [3:0]  out_buf_sel_o;
  logic signed [31:0] out_buf_dat_i;
  logic        enc_valid_o;
  logic        enc_ready_i;
  logic [7:0]  enc_sparsemap_o;
  logic [63:0] enc_nonzero_data_o;
  logic [3:0]  enc_wr_count_o;
  logic        enc_last_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [31:0] buf_mem [16];
  logic [7:0]  cap_map;
  logic [63:0] cap_data;

  output_drain_encoder dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .drain_start_i      (drain_start_i),
    .drain_first_i      (drain_first_i),
    .drain_cnt_i        (drain_cnt_i),
    .scale_shift_i      (scale_shift_i),
    .out_buf_sel_o      (out_buf_sel_o),
    .out_buf_dat_i      (out_buf_dat_i),
    .enc_valid_o        (enc_valid_o),
    .enc_ready_i        (enc_ready_i),
    .enc_sparsemap_o    (enc_sparsemap_o),
    .enc_nonzero_data_o (enc_nonzero_data_o),
    .enc_wr_count_o     (enc_wr_count_o),
    .enc_last_o         (enc_last_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Output buffer with one cycle of read latency.
  always @(posedge clk_i) out_buf_dat_i <= buf_mem[out_buf_sel_o];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Post-processing from plain integer arithmetic: floor((x + 2^s/2) / 2^s), then clamp.
  function automatic logic [7:0] model_q(input logic signed [31:0] v, input int s);
    longint x;
    longint d;
    longint n;
    x = v;
`ifdef DRAIN_RELU_EN
    if (x < 0) x = 0;
`endif
    d = longint'(1) << s;
    n = x + d / 2;
    x = n / d;
    if ((n % d != 0) && (n < 0)) x = x - 1;
`ifdef DRAIN_RELU_EN
    if (x > 255) x = 255;
`else
    if (x > 127) x = 127;
    if (x < -128) x = -128;
`endif
    return x[7:0];
  endfunction

  function automatic logic signed [31:0] rand_val();
    int t;
    case ($urandom_range(0, 3))
      0: t = 0;
      1: t = int'($urandom_range(0, 600)) - 300;
      2: t = int'($urandom());
      default: t = int'($urandom_range(0, 4000));
    endcase
    return t;
  endfunction

  task automatic run_drain(input int first, input int cnt, input int sh, input bit stall);
    logic [7:0]  qv [$];
    logic [7:0]  exp_map;
    logic [63:0] exp_data;
    logic [7:0]  h_map;
    logic [63:0] h_data;
    logic [3:0]  h_sel;
    int nbeats;
    int k;
    int n;
    for (int i = 0; i < cnt; i++) qv.push_back(model_q(buf_mem[(first + i) % 16], sh));
    nbeats = (cnt + 7) / 8;
    @(negedge clk_i);
    drain_first_i = 4'(first);
    drain_cnt_i   = 5'(cnt);
    scale_shift_i = 5'(sh);
    drain_start_i = 1'b1;
    @(negedge clk_i);
    drain_start_i = 1'b0;
    check("busy_start", busy_o, 1);
    for (int b = 0; b < nbeats; b++) begin
      exp_map = '0;
      exp_data = '0;
      k = 0;
      for (int j = 0; j < 8 && (b * 8 + j) < cnt; j++) begin
        if (qv[b * 8 + j] != 8'h00) begin
          exp_map[j] = 1'b1;
          exp_data[k * 8 +: 8] = qv[b * 8 + j];
          k++;
        end
      end
      n = 0;
      while (!enc_valid_o && n < 64) begin
        @(negedge clk_i);
        n++;
      end
      check("beat_valid", enc_valid_o, 1);
      if (stall) begin
        h_map = enc_sparsemap_o;
        h_data = enc_nonzero_data_o;
        h_sel = out_buf_sel_o;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk_i);
          check("stall_valid", enc_valid_o, 1);
          check("stall_map", enc_sparsemap_o, h_map);
          check("stall_data", enc_nonzero_data_o, h_data);
          check("stall_sel", out_buf_sel_o, h_sel);
          check("stall_done", done_o, 0);
        end
      end
      check("map", enc_sparsemap_o, exp_map);
      check("data", enc_nonzero_data_o, exp_data);
      check("last", enc_last_o, (b == nbeats - 1) ? 1 : 0);
      check("wr_count", enc_wr_count_o, 64'(b % 16));
      check("busy_beat", busy_o, 1);
      cap_map = enc_sparsemap_o;
      cap_data = enc_nonzero_data_o;
      enc_ready_i = 1'b1;
      @(negedge clk_i);
      enc_ready_i = 1'b0;
      check("accepted", enc_valid_o, 0);
    end
    n = 0;
    while (!done_o && n < 4) begin
      @(negedge clk_i);
      n++;
    end
    check("done", done_o, 1);
    if (cnt == 0) check("done_latency", (n <= 2) ? 1 : 0, 1);
    @(negedge clk_i);
    check("done_pulse", done_o, 0);
    check("busy_end", busy_o, 0);
    check("idle_valid", enc_valid_o, 0);
  endtask

  task automatic single(input logic signed [31:0] v, input int s, input logic [7:0] exp_q);
    buf_mem[5] = v;
    run_drain(5, 1, s, 1'b0);
    check("pp_byte", cap_data[7:0], exp_q);
    check("pp_map0", cap_map[0], (exp_q != 8'h00) ? 1 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b0;
    drain_start_i = 1'b0;
    drain_first_i = '0;
    drain_cnt_i = '0;
    scale_shift_i = '0;
    enc_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) buf_mem[i] = 0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", enc_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_map", enc_sparsemap_o, 0);
    check("rst_data", enc_nonzero_data_o, 0);
    check("rst_sel", out_buf_sel_o, 0);
    check("rst_wrc", enc_wr_count_o, 0);
    check("rst_last", enc_last_o, 0);
    rst_i = 1'b1;

    // Reset asserted while a beat is being offered.
    for (int i = 0; i < 16; i++) buf_mem[i] = i + 1;
    @(negedge clk_i);
    drain_first_i = 4'd0;
    drain_cnt_i = 5'd3;
    scale_shift_i = 5'd0;
    drain_start_i = 1'b1;
    @(negedge clk_i);
    drain_start_i = 1'b0;
    n = 0;
    while (!enc_valid_o && n < 64) begin
      @(negedge clk_i);
      n++;
    end
    check("pre_rst_valid", enc_valid_o, 1);
    rst_i = 1'b0;
    #1;
    check("async_rst_valid", enc_valid_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_map", enc_sparsemap_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    run_drain(2, 3, 0, 1'b0);

    // Mixed-sign group with saturation.
    buf_mem[0] = 0; buf_mem[1] = 5; buf_mem[2] = -3; buf_mem[3] = 0;
    buf_mem[4] = 300; buf_mem[5] = 1; buf_mem[6] = 0; buf_mem[7] = 2;
    run_drain(0, 8, 0, 1'b0);
`ifdef DRAIN_RELU_EN
    check("t2_map", cap_map, 8'b1011_0010);
    check("t2_data", cap_data, 64'h0000_0000_0201_FF05);
`else
    check("t2_map", cap_map, 8'b1011_0110);
    check("t2_data", cap_data, 64'h0000_0002_017F_FD05);
`endif

    // Wrapping select and a partial tail beat.
    for (int i = 0; i < 16; i++) buf_mem[i] = 7 * i + 1;
    run_drain(14, 10, 0, 1'b0);
    check("t3_tail_map_hi", cap_map[7:2], 0);

    // Back-pressure, then an empty drain.
    for (int i = 0; i < 16; i++) buf_mem[i] = rand_val();
    run_drain(3, 12, 1, 1'b1);
    run_drain(9, 0, 0, 1'b0);

    // Rounding and saturation corners.
    single(6, 2, 8'd2);
    single(5, 1, 8'd3);
    single(0, 0, 8'd0);
`ifdef DRAIN_RELU_EN
    single(-1, 0, 8'd0);
    single(1000, 2, 8'd250);
    single(1020, 2, 8'd255);
`else
    single(-300, 0, 8'h80);
    single(-6, 2, 8'hFF);
    single(200, 0, 8'h7F);
    single(-5, 1, 8'hFE);
`endif

    // Randomized drains.
    for (int t = 0; t < 30; t++) begin
      int sh;
      for (int i = 0; i < 16; i++) buf_mem[i] = rand_val();
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      run_drain(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), sh,
                ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
